// File: rtl/alu_pkg.sv
// alu_pkg: funct codes shared with ALU control and sequencer state encodings
package alu_pkg;
  localparam logic [1:0] FUNCT_ADD = 2'd0;
  localparam logic [1:0] FUNCT_SUB = 2'd1;
  localparam logic [1:0] FUNCT_SLL = 2'd2;
  localparam logic [1:0] FUNCT_OR  = 2'd3;
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_SHIFT  = 1'b1;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational add/sub/or; sll is the first serial step, or a full barrel shift under ALU_SEQ_BARREL_SHIFT_EN
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]               funct,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
`ifdef ALU_SEQ_BARREL_SHIFT_EN
  input  logic [$clog2(WIDTH)-1:0] shamt,
`endif
  output logic [WIDTH-1:0]         y
);
  logic [WIDTH-1:0] sll;
  // shift datapath: whole shift at once, or a single bit for the serial sequencer
  always_comb begin
`ifdef ALU_SEQ_BARREL_SHIFT_EN
    sll = b << shamt;
`else
    sll = b << 1;
`endif
  end
  // operation select
  always_comb
    y = funct == FUNCT_ADD ? a + b :
        funct == FUNCT_SUB ? a - b :
        funct == FUNCT_OR  ? a | b : sll;
endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered execute-stage ALU with start/busy/done; serial sll unless ALU_SEQ_BARREL_SHIFT_EN
module alu_seq #(
  parameter int WIDTH = 32,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         funct,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               zero
);
  import alu_pkg::*;
  logic [WIDTH-1:0] core_y, result_d, result_q;
  logic             done_d, done_q;
  alu_core #(.WIDTH(WIDTH)) u_core (
    .funct(funct),
    .a(src_a),
    .b(src_b),
`ifdef ALU_SEQ_BARREL_SHIFT_EN
    .shamt(shamt),
`endif
    .y(core_y)
  );
`ifdef ALU_SEQ_BARREL_SHIFT_EN
  assign busy = 1'b0;
  // every op completes at the accepting edge
  always_comb begin
    result_d = start ? core_y : result_q;
    done_d   = start;
  end
`else
  logic [0:0]         state_d, state_q;
  logic [SHAMT_W-1:0] count_d, count_q;
  logic               sll_long;
  assign sll_long = funct == FUNCT_SLL && shamt > SHAMT_W'(1);
  assign busy     = state_q == ST_SHIFT;
  // accept in IDLE, then shift one bit per cycle until the count runs out
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    result_d = result_q;
    done_d   = 1'b0;
    if (state_q == ST_SHIFT) begin
      result_d = result_q << 1;
      count_d  = count_q - 1'b1;
      done_d   = count_q == SHAMT_W'(1);
      state_d  = count_q == SHAMT_W'(1) ? ST_IDLE : ST_SHIFT;
    end else if (start) begin
      result_d = funct == FUNCT_SLL && shamt == '0 ? src_b : core_y;
      count_d  = sll_long ? shamt - 1'b1 : count_q;
      done_d   = !sll_long;
      state_d  = sll_long ? ST_SHIFT : ST_IDLE;
    end
  end
  // sequencer state and remaining shift count
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
`endif
  // result and done pulse; reset discards any partial shift
  always_ff @(posedge clk)
    if (rst) begin
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      done_q   <= done_d;
    end
  assign result = result_q;
  assign done   = done_q;
  assign zero   = result_q == '0;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and random ops against an arithmetic reference model
module tb_alu_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  funct = 2'd0;
  logic [31:0] src_a = '0, src_b = '0;
  logic [4:0]  shamt = '0;
  logic        busy, done, zero;
  logic [31:0] result;
  int          n_vec = 0, n_err = 0;
  alu_seq dut (
    .clk(clk), .rst(rst), .start(start), .funct(funct), .src_a(src_a), .src_b(src_b),
    .shamt(shamt), .busy(busy), .done(done), .result(result), .zero(zero)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] model(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b, input int s);
    case (f)
      2'd0: return a + b;
      2'd1: return a - b;
      2'd2: return b << s;
      default: return a | b;
    endcase
  endfunction
  function automatic int model_lat(input logic [1:0] f, input int s);
`ifdef ALU_SEQ_BARREL_SHIFT_EN
    return 1;
`else
    return (f == 2'd2 && s > 1) ? s : 1;
`endif
  endfunction
  // called at a negedge; returns at the negedge where done is seen, so the next call issues during the done cycle
  task automatic run_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] s, input bit noise);
    logic [31:0] exp;
    int n;
    exp = model(f, a, b, int'(s));
    start = 1'b1; funct = f; src_a = a; src_b = b; shamt = s;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 64) begin
`ifdef ALU_SEQ_BARREL_SHIFT_EN
      check("busy_wait", {31'b0, busy}, 32'd0);
`else
      check("busy_wait", {31'b0, busy}, 32'd1);
`endif
      if (noise) begin
        start = 1'($urandom_range(0, 1)); funct = 2'($urandom); src_a = $urandom; src_b = $urandom; shamt = 5'($urandom);
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("latency", n, model_lat(f, int'(s)));
    check("result", result, exp);
    check("zero", {31'b0, zero}, {31'b0, exp == 0});
    check("busy_done", {31'b0, busy}, 32'd0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("rst_result", result, 32'd0);
    check("rst_zero", {31'b0, zero}, 32'd1);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_done", {31'b0, done}, 32'd0);
    run_op(2'd0, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0);
    run_op(2'd1, 32'd5, 32'd7, 5'd0, 1'b0);
    run_op(2'd3, 32'hF0, 32'h0F, 5'd0, 1'b0);
    @(negedge clk);
    check("pulse_one", {31'b0, done}, 32'd0);
    run_op(2'd2, 32'd0, 32'h1, 5'd31, 1'b1);
    run_op(2'd2, 32'd0, 32'h1234, 5'd0, 1'b0);
    run_op(2'd2, 32'd0, 32'h8000_0001, 5'd1, 1'b0);
    run_op(2'd2, 32'd0, 32'hA5A5_A5A5, 5'd2, 1'b1);
    @(negedge clk);
`ifndef ALU_SEQ_BARREL_SHIFT_EN
    start = 1'b1; funct = 2'd2; src_b = 32'hDEAD_BEEF; shamt = 5'd8;
    @(negedge clk);
    start = 1'b0;
    repeat (2) begin
      check("pre_rst_done", {31'b0, done}, 32'd0);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_result", result, 32'd0);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_zero", {31'b0, zero}, 32'd1);
    repeat (12) begin
      check("mid_rst_no_done", {31'b0, done}, 32'd0);
      @(negedge clk);
    end
`endif
    repeat (200) begin
      run_op(2'($urandom), $urandom, $urandom, 5'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        check("rand_pulse", {31'b0, done}, 32'd0);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Registered execute-stage ALU that sits directly downstream of the ALU control decoder: it consumes the 2-bit `funct` code (0 add, 1 sub, 2 shift-left-logical, 3 or) together with the two operands and the shift amount. It produces a registered result with a start/busy/done handshake. Add, sub and or complete in one cycle. Shift-left-logical is executed serially, one bit per cycle, unless the barrel-shift option is compiled in. The datapath sequencer waits on `done` before writing back.

## Interface
- `WIDTH`, 32, operand/result width in bits.
- `SHAMT_W`, `$clog2(WIDTH)` (5), shift-amount width; derived, not overridden.
- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request; sampled only when `busy`=0.
- `funct` in 2: operation code from ALU control (0 +, 1 −, 2 <<, 3 |).
- `src_a` in WIDTH: operand A (add/sub/or).
- `src_b` in WIDTH: operand B; the value shifted for sll.
- `shamt` in SHAMT_W: shift amount for sll; ignored otherwise.
- `busy` out 1: serial shift in progress; new `start` ignored.
- `done` out 1: one-cycle pulse, `result` valid from this cycle until next accepted op.
- `result` out WIDTH: registered result.
- `zero` out 1: `result`==0, combinational from the result register.

## Operation
- States: IDLE, SHIFT.
- IDLE, `start`=1 at edge: capture `funct`, `src_b`, `shamt`.
  - add: `result`<=`src_a`+`src_b` mod 2^WIDTH.
  - sub: `result`<=`src_a`−`src_b` mod 2^WIDTH.
  - or: `result`<=`src_a`|`src_b`.
  - For add/sub/or, `done`<=1 and the state stays IDLE.
  - sll, `shamt`=0: `result`<=`src_b`, `done`<=1, stay IDLE.
  - sll, `shamt`≥1: `result`<=`src_b`<<1, `count`<=`shamt`−1.
    - If `count` would be 0: `done`<=1 and stay IDLE.
    - Otherwise: go to SHIFT with `busy`<=1.
- SHIFT, each edge: `result`<=`result`<<1 and `count`<=`count`−1.
  - When `count`==1: `done`<=1, `busy`<=0, state returns to IDLE.
- Arithmetic flags: no overflow or carry (unsigned add/sub); bits shifted out are discarded and zeros shift in.
- `start` while `busy`=1: ignored; no queueing.
- `start` in the same cycle as `done`=1 (state IDLE): accepted, which gives back-to-back ops.
- `done` is a registered pulse, high for exactly one cycle per accepted op.

## Timing
- Reset values: state IDLE, `result`=0, `zero`=1, `done`=0, `busy`=0, `count`=0.
- `rst` has priority over everything, including mid-SHIFT; the partial result is discarded and no `done` is produced.
- Latency, counted from the accepting edge to the cycle in which `done`=1:
  - add/sub/or: 1 cycle.
  - sll: max(1, `shamt`) cycles.
- `busy` is high from the edge after accept through the edge that raises `done`; it is low in the `done` cycle.
- Throughput: one op per cycle for non-shift ops.

## Configuration
- `ALU_SEQ_BARREL_SHIFT_EN` defined: sll computes `src_b`<<`shamt` combinationally at the accepting edge. Latency is 1 for every op, SHIFT state and `count` are removed, and `busy` is tied to 0.
- Undefined: serial shift as described above (area-minimal default).

## Structure
- Package `alu_pkg` holds:
  - the funct encodings `FUNCT_ADD`=2'd0, `FUNCT_SUB`=2'd1, `FUNCT_SLL`=2'd2, `FUNCT_OR`=2'd3, shared with ALU control;
  - the state encodings `ST_IDLE` and `ST_SHIFT`.
- One sub-module `alu_core`: purely combinational add/sub/or (plus barrel shift under the macro).
- `alu_seq` owns the FSM, counter, and result/done/busy registers.

## Test plan
- Reset then idle: `result`=0, `zero`=1, `done`=0, `busy`=0.
- add A=0xFFFFFFFF, B=1 → `done` after 1 cycle, `result`=0, `zero`=1.
- Back-to-back ops:
  - sub A=5, B=7 → `result`=0xFFFFFFFE after 1 cycle.
  - Then or A=0xF0, B=0x0F issued during that `done` cycle → 0xFF one cycle later.
- sll B=0x1, `shamt`=31 → `busy` high 30 cycles, `done` at cycle 31, `result`=0x80000000.
- sll `shamt`=0, B=0x1234 → `done` at cycle 1, `result`=0x1234.
- Extra `start` during `busy` is ignored.
- sll `shamt`=8 with `rst` asserted at cycle 4 → next cycle IDLE, `result`=0, and no `done` pulse ever.
- With `ALU_SEQ_BARREL_SHIFT_EN` defined, the same sll `shamt`=31 case gives `done` at cycle 1.
